// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: takes exceptions, external interrupts and mret
// for the committing instruction, owns the trap CSRs and drives stall/flush/redirect.
module trap_controller #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_1000,
    parameter logic [1:0]  RESET_PRIV  = 2'b11
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_exception,
    input  logic [3:0]  i_cause,
    input  logic [31:0] i_PC,
    input  logic [31:0] i_inst,
    input  logic        i_mret,
    input  logic        i_irq,
    input  logic        i_csrWe,
    input  logic [11:0] i_csrAddr,
    input  logic [31:0] i_csrWdata,
    output logic [31:0] o_csrRdata,
    output logic [1:0]  o_privMode,
    output logic        o_stall,
    output logic        o_flush,
    output logic        o_redirect,
    output logic [31:0] o_redirectPC
);

    typedef enum logic [1:0] {IDLE, SAVE, JUMP, RET} stateType;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [1:0]  PRIV_M       = 2'b11;

    stateType    state;
    logic [31:0] mepc, mcause, mtval, mtvec;
    logic        mie, mpie;
    logic [1:0]  mpp;
    logic [3:0]  savedCause;
    logic        savedIrq;
    logic [31:0] savedPC, savedInst;

    logic takeExc, takeIrq, takeMret, csrWrite;

    // Request priority for the committing instruction: exception > interrupt > mret > CSR write.
    assign takeExc  = i_valid && i_exception;
    assign takeIrq  = i_valid && !i_exception && i_irq && mie;
    assign takeMret = i_valid && !i_exception && !takeIrq && i_mret;
    assign csrWrite = i_valid && i_csrWe && !i_exception && !takeIrq && !i_mret;

    always_comb begin
        // NOTE: default first so every path assigns o_csrRdata and no latch is inferred.
        o_csrRdata = 32'h0;
        unique case (i_csrAddr)
            ADDR_MSTATUS: o_csrRdata = {19'b0, mpp, 3'b0, mpie, 3'b0, mie, 3'b0};
            ADDR_MTVEC:   o_csrRdata = {mtvec[31:2], 2'b00};
            ADDR_MEPC:    o_csrRdata = {mepc[31:2], 2'b00};
            ADDR_MCAUSE:  o_csrRdata = mcause;
            ADDR_MTVAL:   o_csrRdata = mtval;
            default:      o_csrRdata = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_privMode   <= RESET_PRIV;
            mtvec        <= RESET_MTVEC;
            mepc         <= 32'h0;
            mcause       <= 32'h0;
            mtval        <= 32'h0;
            mie          <= 1'b0;
            mpie         <= 1'b0;
            mpp          <= 2'b00;
            savedCause   <= 4'h0;
            savedIrq     <= 1'b0;
            savedPC      <= 32'h0;
            savedInst    <= 32'h0;
            o_stall      <= 1'b0;
            o_flush      <= 1'b0;
            o_redirect   <= 1'b0;
            o_redirectPC <= 32'h0;
        end else begin
            // NOTE: non-blocking throughout so every register updates from pre-edge values.
            unique case (state)
                IDLE: begin
                    o_redirect   <= 1'b0;
                    o_redirectPC <= 32'h0;
                    if (takeExc || takeIrq) begin
                        state      <= SAVE;
                        savedCause <= i_cause;
                        savedIrq   <= takeIrq;
                        savedPC    <= i_PC;
                        savedInst  <= i_inst;
                        o_stall    <= 1'b1;
                        o_flush    <= 1'b1;
                    end else if (takeMret) begin
                        state        <= RET;
                        o_stall      <= 1'b1;
                        o_flush      <= 1'b1;
                        o_redirect   <= 1'b1;
                        o_redirectPC <= {mepc[31:2], 2'b00};
                    end else begin
                        o_stall <= 1'b0;
                        o_flush <= 1'b0;
                        if (csrWrite) begin
                            unique case (i_csrAddr)
                                ADDR_MSTATUS: begin
                                    mie  <= i_csrWdata[3];
                                    mpie <= i_csrWdata[7];
                                    mpp  <= i_csrWdata[12:11];
                                end
                                ADDR_MTVEC:  mtvec  <= {i_csrWdata[31:2], 2'b00};
                                ADDR_MEPC:   mepc   <= {i_csrWdata[31:2], 2'b00};
                                ADDR_MCAUSE: mcause <= i_csrWdata;
                                ADDR_MTVAL:  mtval  <= i_csrWdata;
                                default: ;
                            endcase
                        end
                    end
                end
                SAVE: begin
                    mepc <= {savedPC[31:2], 2'b00};
                    if (savedIrq) begin
                        mcause <= 32'h8000_000B;
                        mtval  <= 32'h0;
                    end else begin
                        mcause <= {28'b0, savedCause};
                        unique case (savedCause)
                            4'd0, 4'd1: mtval <= savedPC;
                            4'd2:       mtval <= savedInst;
                            default:    mtval <= 32'h0;
                        endcase
                    end
                    mpie         <= mie;
                    mie          <= 1'b0;
                    mpp          <= o_privMode;
                    o_privMode   <= PRIV_M;
                    state        <= JUMP;
                    o_stall      <= 1'b1;
                    o_flush      <= 1'b0;
                    o_redirect   <= 1'b1;
                    o_redirectPC <= {mtvec[31:2], 2'b00};
                end
                JUMP: begin
                    state        <= IDLE;
                    o_stall      <= 1'b0;
                    o_flush      <= 1'b0;
                    o_redirect   <= 1'b0;
                    o_redirectPC <= 32'h0;
                end
                RET: begin
                    o_privMode   <= mpp;
                    mie          <= mpie;
                    mpie         <= 1'b1;
                    mpp          <= 2'b00;
                    state        <= IDLE;
                    o_stall      <= 1'b0;
                    o_flush      <= 1'b0;
                    o_redirect   <= 1'b0;
                    o_redirectPC <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: trap entry, interrupt masking, mret,
// request priority, misaligned PC, CSR map and reset during a trap.
module tb_trap_controller;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_exception = 1'b0;
    logic [3:0]  i_cause = 4'h0;
    logic [31:0] i_PC = 32'h0;
    logic [31:0] i_inst = 32'h0;
    logic        i_mret = 1'b0;
    logic        i_irq = 1'b0;
    logic        i_csrWe = 1'b0;
    logic [11:0] i_csrAddr = 12'h0;
    logic [31:0] i_csrWdata = 32'h0;
    logic [31:0] o_csrRdata;
    logic [1:0]  o_privMode;
    logic        o_stall, o_flush, o_redirect;
    logic [31:0] o_redirectPC;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd;

    trap_controller dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_exception(i_exception),
        .i_cause(i_cause), .i_PC(i_PC), .i_inst(i_inst), .i_mret(i_mret), .i_irq(i_irq),
        .i_csrWe(i_csrWe), .i_csrAddr(i_csrAddr), .i_csrWdata(i_csrWdata),
        .o_csrRdata(o_csrRdata), .o_privMode(o_privMode), .o_stall(o_stall),
        .o_flush(o_flush), .o_redirect(o_redirect), .o_redirectPC(o_redirectPC)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic readCsr(input logic [11:0] addr, output logic [31:0] data);
        i_csrAddr = addr;
        #1;
        data = o_csrRdata;
    endtask

    // Present one committing instruction for a single edge, then retire the strobes.
    task automatic commit(input logic exc, input logic [3:0] cause, input logic [31:0] pc,
                          input logic [31:0] inst, input logic mret, input logic we,
                          input logic [11:0] addr, input logic [31:0] wdata);
        i_valid = 1'b1; i_exception = exc; i_cause = cause; i_PC = pc; i_inst = inst;
        i_mret = mret; i_csrWe = we; i_csrAddr = addr; i_csrWdata = wdata;
        tick();
        i_valid = 1'b0; i_exception = 1'b0; i_mret = 1'b0; i_csrWe = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick();
        checks++;
        if ({o_stall, o_flush, o_redirect} !== 3'b000 || o_redirectPC !== 32'h0) begin
            failures++;
            $display("FAIL reset_strobes got=%b/%h exp=000/00000000", {o_stall, o_flush, o_redirect}, o_redirectPC);
        end
        checks++;
        if (o_privMode !== 2'b11) begin failures++; $display("FAIL reset_priv got=%b exp=11", o_privMode); end
        readCsr(12'h305, rd);
        checks++;
        if (rd !== 32'h0000_1000) begin failures++; $display("FAIL reset_mtvec got=%h exp=00001000", rd); end
        readCsr(12'h300, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_mstatus got=%h exp=00000000", rd); end
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick();
    endtask

    // mret from M with MPP=00 drops the core into U-mode.
    task automatic test_mret_to_user();
        commit(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 12'h0, 32'h0);
        checks++;
        if ({o_stall, o_flush, o_redirect} !== 3'b111 || o_redirectPC !== 32'h0) begin
            failures++;
            $display("FAIL mret_user_ret got=%b/%h exp=111/00000000", {o_stall, o_flush, o_redirect}, o_redirectPC);
        end
        tick();
        checks++;
        if (o_privMode !== 2'b00 || o_stall !== 1'b0) begin
            failures++; $display("FAIL mret_user_priv got=%b/%b exp=00/0", o_privMode, o_stall);
        end
    endtask

    task automatic test_illegal();
        commit(1'b1, 4'd2, 32'h0001_0040, 32'hFFFF_FFFF, 1'b0, 1'b0, 12'h0, 32'h0);
        checks++;
        if ({o_stall, o_flush, o_redirect} !== 3'b110) begin
            failures++; $display("FAIL illegal_save got=%b exp=110", {o_stall, o_flush, o_redirect});
        end
        tick();
        checks++;
        if ({o_stall, o_flush, o_redirect} !== 3'b101 || o_redirectPC !== 32'h0000_1000) begin
            failures++;
            $display("FAIL illegal_jump got=%b/%h exp=101/00001000", {o_stall, o_flush, o_redirect}, o_redirectPC);
        end
        tick();
        checks++;
        if ({o_stall, o_flush, o_redirect} !== 3'b000) begin
            failures++; $display("FAIL illegal_idle got=%b exp=000", {o_stall, o_flush, o_redirect});
        end
        readCsr(12'h341, rd);
        checks++;
        if (rd !== 32'h0001_0040) begin failures++; $display("FAIL illegal_mepc got=%h exp=00010040", rd); end
        readCsr(12'h342, rd);
        checks++;
        if (rd !== 32'h2) begin failures++; $display("FAIL illegal_mcause got=%h exp=00000002", rd); end
        readCsr(12'h343, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL illegal_mtval got=%h exp=ffffffff", rd); end
        readCsr(12'h300, rd);
        checks++;
        if (rd !== 32'h0 || o_privMode !== 2'b11) begin
            failures++; $display("FAIL illegal_mstatus got=%h/%b exp=00000000/11", rd, o_privMode);
        end
    endtask

    task automatic test_irq();
        commit(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 12'h300, 32'h0000_0008);
        i_irq = 1'b1;
        commit(1'b0, 4'h0, 32'h0000_2000, 32'h13, 1'b0, 1'b0, 12'h0, 32'h0);
        checks++;
        if ({o_stall, o_flush, o_redirect} !== 3'b110) begin
            failures++; $display("FAIL irq_save got=%b exp=110", {o_stall, o_flush, o_redirect});
        end
        tick();
        checks++;
        if (o_redirect !== 1'b1 || o_redirectPC !== 32'h0000_1000) begin
            failures++; $display("FAIL irq_jump got=%b/%h exp=1/00001000", o_redirect, o_redirectPC);
        end
        tick();
        // i_irq stays high with commits flowing: MIE=0 must block re-entry.
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_PC = 32'h0000_2004 + 32'(k * 4);
            tick();
            checks++;
            if (o_stall !== 1'b0) begin failures++; $display("FAIL irq_reentry[%0d] got=%b exp=0", k, o_stall); end
        end
        i_valid = 1'b0;
        readCsr(12'h342, rd);
        checks++;
        if (rd !== 32'h8000_000B) begin failures++; $display("FAIL irq_mcause got=%h exp=8000000b", rd); end
        readCsr(12'h341, rd);
        checks++;
        if (rd !== 32'h0000_2000) begin failures++; $display("FAIL irq_mepc got=%h exp=00002000", rd); end
        readCsr(12'h300, rd);
        checks++;
        if (rd !== 32'h0000_1880) begin failures++; $display("FAIL irq_mstatus got=%h exp=00001880", rd); end
        readCsr(12'h343, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL irq_mtval got=%h exp=00000000", rd); end
    endtask

    task automatic test_mret_return();
        commit(1'b0, 4'h0, 32'h0000_2100, 32'h3020_0073, 1'b1, 1'b0, 12'h0, 32'h0);
        i_irq = 1'b0;
        checks++;
        if ({o_stall, o_flush, o_redirect} !== 3'b111 || o_redirectPC !== 32'h0000_2000) begin
            failures++;
            $display("FAIL mret_ret got=%b/%h exp=111/00002000", {o_stall, o_flush, o_redirect}, o_redirectPC);
        end
        tick();
        readCsr(12'h300, rd);
        checks++;
        if (rd !== 32'h0000_0088 || o_privMode !== 2'b11) begin
            failures++; $display("FAIL mret_state got=%h/%b exp=00000088/11", rd, o_privMode);
        end
    endtask

    task automatic test_priority();
        i_irq = 1'b1;
        commit(1'b1, 4'd8, 32'h0000_3000, 32'h0000_0073, 1'b0, 1'b1, 12'h305, 32'h0000_5000);
        i_irq = 1'b0;
        tick();
        checks++;
        if (o_redirectPC !== 32'h0000_1000) begin failures++; $display("FAIL prio_jump got=%h exp=00001000", o_redirectPC); end
        tick();
        readCsr(12'h342, rd);
        checks++;
        if (rd !== 32'h8) begin failures++; $display("FAIL prio_mcause got=%h exp=00000008", rd); end
        readCsr(12'h343, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL prio_mtval got=%h exp=00000000", rd); end
        readCsr(12'h305, rd);
        checks++;
        if (rd !== 32'h0000_1000) begin failures++; $display("FAIL prio_mtvec got=%h exp=00001000", rd); end
        readCsr(12'h300, rd);
        checks++;
        if (rd !== 32'h0000_1880) begin failures++; $display("FAIL prio_mstatus got=%h exp=00001880", rd); end
    endtask

    task automatic test_misaligned();
        commit(1'b1, 4'd0, 32'h0000_0102, 32'h0000_0013, 1'b0, 1'b0, 12'h0, 32'h0);
        tick();
        tick();
        readCsr(12'h343, rd);
        checks++;
        if (rd !== 32'h0000_0102) begin failures++; $display("FAIL misal_mtval got=%h exp=00000102", rd); end
        readCsr(12'h341, rd);
        checks++;
        if (rd !== 32'h0000_0100) begin failures++; $display("FAIL misal_mepc got=%h exp=00000100", rd); end
    endtask

    task automatic test_csr_map();
        commit(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 12'h305, 32'h0000_4003);
        commit(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 12'h341, 32'h0000_1237);
        commit(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 12'h7C0, 32'hA5A5_A5A5);
        commit(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 12'h300, 32'hFFFF_FFFF);
        readCsr(12'h305, rd);
        checks++;
        if (rd !== 32'h0000_4000) begin failures++; $display("FAIL csr_mtvec got=%h exp=00004000", rd); end
        readCsr(12'h341, rd);
        checks++;
        if (rd !== 32'h0000_1234) begin failures++; $display("FAIL csr_mepc got=%h exp=00001234", rd); end
        readCsr(12'h7C0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL csr_unmapped got=%h exp=00000000", rd); end
        readCsr(12'h300, rd);
        checks++;
        if (rd !== 32'h0000_1888) begin failures++; $display("FAIL csr_mstatus got=%h exp=00001888", rd); end
        commit(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 12'h300, 32'h0);
    endtask

    task automatic test_reset_mid_trap();
        commit(1'b1, 4'd2, 32'h0000_0500, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'h0, 32'h0);
        tick();
        checks++;
        if (o_redirect !== 1'b1 || o_redirectPC !== 32'h0000_4000) begin
            failures++; $display("FAIL rstmid_jump got=%b/%h exp=1/00004000", o_redirect, o_redirectPC);
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_stall, o_flush, o_redirect} !== 3'b000 || o_privMode !== 2'b11) begin
            failures++; $display("FAIL rstmid_out got=%b/%b exp=000/11", {o_stall, o_flush, o_redirect}, o_privMode);
        end
        readCsr(12'h305, rd);
        checks++;
        if (rd !== 32'h0000_1000) begin failures++; $display("FAIL rstmid_mtvec got=%h exp=00001000", rd); end
        readCsr(12'h341, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_mepc got=%h exp=00000000", rd); end
        readCsr(12'h342, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_mcause got=%h exp=00000000", rd); end
        readCsr(12'h343, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_mtval got=%h exp=00000000", rd); end
        readCsr(12'h300, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_mstatus got=%h exp=00000000", rd); end
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_mret_to_user();
        test_illegal();
        test_irq();
        test_mret_return();
        test_priority();
        test_misaligned();
        test_csr_map();
        test_reset_mid_trap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
